seq_detector_param: RTL
=======================

Name: seq_detector_param

Overview:
Parametrised successor to the team's two-input Mealy sequence detectors. It watches a stream of SYM_W-bit symbols qualified by a valid strobe and pulses y when the last SEQ_LEN accepted symbols equal a runtime-loadable pattern. The block supports overlapping and non-overlapping detection and keeps a saturating match counter. It sits between input synchronisers and the lab display/LED logic.

Parameters:
SYM_W, 2, width of one input symbol in bits (1..8)
SEQ_LEN, 3, pattern length in symbols (2..16)
CNT_W, 8, width of the saturating match counter

Ports:
clk  input  1  system clock; all state is updated on the rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
sym  input  SYM_W  input symbol
sym_valid  input  1  sym is accepted on a rising edge when this is 1
pattern  input  SYM_W*SEQ_LEN  target sequence; bits [SYM_W-1:0] hold the first (oldest) symbol
pat_load  input  1  latch pattern into the internal register and clear the history
overlap  input  1  1 = overlapping detection, 0 = non-overlapping
y  output  1  registered one-cycle match pulse
match_cnt  output  CNT_W  number of matches, saturating
busy  output  1  history holds at least one symbol, i.e. fill > 0

Behaviour:
- Reset (reset=0, asynchronous): pat_reg, hist and fill go to 0; y=0; match_cnt=0; busy=0. Deasserting reset does not start activity until the next valid edge.
- State:
  - pat_reg: latched pattern.
  - hist: shift register of the last SEQ_LEN symbols; the newest symbol enters the top slot and the oldest drops out.
  - fill: number of valid symbols held, 0..SEQ_LEN, saturating at SEQ_LEN.
- Accepting a symbol (sym_valid=1, pat_load=0):
  - hist shifts the symbol in.
  - fill_next = min(fill+1, SEQ_LEN).
  - hit = (fill_next==SEQ_LEN) && (hist_next == pat_reg).
- On hit:
  - y=1 on the following cycle only.
  - match_cnt increments, holding at 2^CNT_W-1.
  - If overlap=1, fill stays at SEQ_LEN, so the next symbol can complete a new match.
  - If overlap=0, fill is forced to 0, so the history must refill completely before the next match.
- Latency: the last symbol of a pattern is sampled on edge k; y is high from edge k until edge k+1.
- sym_valid=0: hist, fill and match_cnt hold; y=0 on the next cycle. Gaps between valid symbols do not break a sequence.
- pat_load=1: pat_reg<=pattern, fill<=0, y<=0. match_cnt is not cleared. pat_load has priority over a simultaneous sym_valid, and that symbol is dropped.
- overlap is sampled on every hit. Changing it mid-stream takes effect at the next hit.
- The match condition uses only the SEQ_LEN most recent accepted symbols. No partial-match fallback logic exists, and none is needed because hist is compared in full.
- y is registered, never combinational from sym.
- match_cnt saturation: at the all-ones value a further hit still pulses y, but the count does not wrap.
- Reset asserted mid-sequence: all state clears immediately and any pending y pulse is lost.

Decomposition:
- A shared package holds:
  - the mode constants OVERLAP=1'b1 and NON_OVERLAP=1'b0;
  - a function computing the SYM_W*SEQ_LEN pattern width;
  - the saturating-increment helper, shared with the team's other counters.
- One sub-module is natural: sat_counter (parameter CNT_W; inputs inc and reset; output cnt). It is reusable by the other lab blocks.
- The shift history and the comparator stay in the top module.

Test Plan:
- SYM_W=2, SEQ_LEN=3, load pattern {11,10,01}, meaning first symbol 01. Stream 01,10,11 with valid on every cycle -> y=1 exactly one cycle after the third symbol; match_cnt=1.
- Same pattern, stream 01,10,00,01,10,11 -> a single y pulse after the final 11 only; busy=1 from the first accepted symbol.
- Pattern 01,01 (SEQ_LEN=2), stream 01,01,01,01:
  - overlap=1 -> y pulses after symbols 2, 3 and 4; match_cnt=3.
  - after reset, overlap=0 -> pulses after symbols 2 and 4; match_cnt=2.
- Stream 01,10 with sym_valid low for 5 cycles, then 11 -> y pulses once; y stays 0 during the gap.
- Drive pat_load=1 and sym_valid=1 on the same edge, mid-sequence -> the symbol is dropped, fill=0, and no match occurs until 3 new valid symbols arrive. match_cnt keeps its previous value.
- CNT_W=2, feed 5 matches -> match_cnt reads 1, 2, 3, 3, 3 and y pulses 5 times. Then pulse reset low asynchronously between edges -> y=0, match_cnt=0 and busy=0 immediately.

Source files
------------

// File: rtl/seq_detector_param_pkg.sv
// Shared constants and helpers for the parametrised sequence detector and
// the lab counters that reuse the saturating increment.
package seq_detector_param_pkg;

    // Detection mode values carried on the overlap input
    localparam logic OVERLAP     = 1'b1;
    localparam logic NON_OVERLAP = 1'b0;

    // Total width of a packed pattern of seq_len symbols of sym_w bits
    function automatic int pat_width(input int sym_w, input int seq_len);
        return sym_w * seq_len;
    endfunction

    // Increment that sticks at max_val instead of wrapping
    function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                            input logic [31:0] max_val);
        if (val >= max_val) begin
            return max_val;
        end else begin
            return val + 32'd1;
        end
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc pulses and holds at all-ones.
module sat_counter
    import seq_detector_param_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;

    // Next count: step on inc, never wrapping past the maximum
    always_comb begin
        cnt_next_s = cnt_r;
        if (inc) begin
            cnt_next_s = CNT_W'(sat_inc(32'(cnt_r), 32'(CNT_MAX)));
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Count register, cleared asynchronously by the active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_next_s;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/seq_detector_param.sv
// Pattern detector over a valid-qualified symbol stream. The newest symbol
// enters the top slot of the history so that the history lines up with the
// pattern layout (lowest slot = oldest symbol), allowing a full compare.
module seq_detector_param
    import seq_detector_param_pkg::*;
#(
    parameter int SYM_W   = 2,
    parameter int SEQ_LEN = 3,
    parameter int CNT_W   = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [SYM_W-1:0]                      sym,
    input  logic                                  sym_valid,
    input  logic [pat_width(SYM_W, SEQ_LEN)-1:0]  pattern,
    input  logic                                  pat_load,
    input  logic                                  overlap,
    output logic                                  y,
    output logic [CNT_W-1:0]                      match_cnt,
    output logic                                  busy
);

    localparam int PAT_W  = pat_width(SYM_W, SEQ_LEN);
    localparam int FILL_W = $clog2(SEQ_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SEQ_LEN);

    logic [PAT_W-1:0]  pat_r;
    logic [PAT_W-1:0]  hist_r;
    logic [FILL_W-1:0] fill_r;
    logic              y_r;
    logic              busy_r;

    logic [PAT_W-1:0]  pat_next_s;
    logic [PAT_W-1:0]  hist_next_s;
    logic [FILL_W-1:0] fill_acc_s;
    logic [FILL_W-1:0] fill_next_s;
    logic              hit_s;

    // Next history, fill level and match decision for this edge
    always_comb begin
        pat_next_s  = pat_r;
        hist_next_s = hist_r;
        fill_acc_s  = fill_r;
        fill_next_s = fill_r;
        hit_s       = 1'b0;
        if (pat_load) begin
            // A load wins over a simultaneous symbol, which is dropped
            pat_next_s  = pattern;
            hist_next_s = {PAT_W{1'b0}};
            fill_next_s = {FILL_W{1'b0}};
        end else if (sym_valid) begin
            hist_next_s = {sym, hist_r[PAT_W-1:SYM_W]};
            fill_acc_s  = FILL_W'(sat_inc(32'(fill_r), 32'(SEQ_LEN)));
            hit_s       = (fill_acc_s == FILL_FULL) && (hist_next_s == pat_r);
            if (hit_s && (overlap == NON_OVERLAP)) begin
                fill_next_s = {FILL_W{1'b0}};
            end else begin
                fill_next_s = fill_acc_s;
            end
        end else begin
            hist_next_s = hist_r;
            fill_next_s = fill_r;
        end
    end

    // Pattern, history and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_r  <= {PAT_W{1'b0}};
            hist_r <= {PAT_W{1'b0}};
            fill_r <= {FILL_W{1'b0}};
            y_r    <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            pat_r  <= pat_next_s;
            hist_r <= hist_next_s;
            fill_r <= fill_next_s;
            y_r    <= hit_s;
            busy_r <= (fill_next_s != {FILL_W{1'b0}});
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (hit_s),
        .cnt   (match_cnt)
    );

    assign y    = y_r;
    assign busy = busy_r;

endmodule
